// File: rtl/trig_capture_ctrl_pkg.sv
// Shared types and constants for the logic-analyzer capture controller.
// State encoding and trigger-source bit positions within the trig_src mask.
package trig_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_ARMED,
        ST_POSTTRIG,
        ST_DONE
    } cap_state_t;

    localparam int TRIG_SPI  = 0;
    localparam int TRIG_UART = 1;
    localparam int TRIG_EXT  = 2;

endpackage

// File: rtl/trig_capture_ctrl_trig_sel.sv
// Trigger source masking and pending latch: a pulse seen while armed is held
// until the next sample strobe consumes it, so pulses between strobes are not lost.
module trig_sel
    import trig_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    input  logic       i_window,
    input  logic       i_consume,
    input  logic       i_spi,
    input  logic       i_uart,
    input  logic       i_ext,
    input  logic [2:0] i_src,
    output logic       o_trig_now
);

    logic [2:0] w_pulses;
    logic       w_hit;
    logic       r_pending;

    always_comb begin
        w_pulses            = '0;
        w_pulses[TRIG_SPI]  = i_spi;
        w_pulses[TRIG_UART] = i_uart;
        w_pulses[TRIG_EXT]  = i_ext;
    end

    // Outside the armed window pulses never reach the latch or the output.
    assign w_hit      = i_window & (|(i_src & w_pulses));
    assign o_trig_now = r_pending | w_hit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_run) begin
            r_pending <= 1'b0;
        end else if (i_consume) begin
            r_pending <= 1'b0;
        end else if (w_hit) begin
            r_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/trig_capture_ctrl.sv
// Capture controller: circular sample-RAM write addressing with pre-trigger fill,
// trigger acceptance on a sample strobe and a programmable post-trigger tail.
module trig_capture_ctrl
    import trig_capture_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clr_done,
    input  logic              cap_en,
    input  logic              SPItrig,
    input  logic              UARTtrig,
    input  logic              ext_trig,
    input  logic [2:0]        trig_src,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    cap_state_t        r_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_armed;
    logic              r_triggered;
    logic              r_capture_done;

    logic              w_we;
    logic              w_window;
    logic              w_consume;
    logic              w_trig_now;
    logic [CNT_W-1:0]  w_pre_target;
    logic [CNT_W-1:0]  w_cnt_inc;

    // trig_pos is ADDR_W wide, so it can never exceed DEPTH-1 and needs no clamp.
    assign w_pre_target = CNT_W'(DEPTH) - {1'b0, trig_pos};
    assign w_cnt_inc    = r_cnt + 1'b1;

    assign w_we      = cap_en && (r_state == ST_PRETRIG || r_state == ST_ARMED
                                  || r_state == ST_POSTTRIG);
    assign w_window  = (r_state == ST_ARMED);
    assign w_consume = w_window && cap_en;

    trig_sel u_trig_sel (
        .clk        (clk),
        .rst        (rst),
        .i_run      (run),
        .i_window   (w_window),
        .i_consume  (w_consume),
        .i_spi      (SPItrig),
        .i_uart     (UARTtrig),
        .i_ext      (ext_trig),
        .i_src      (trig_src),
        .o_trig_now (w_trig_now)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_waddr        <= '0;
            r_trig_addr    <= '0;
            r_cnt          <= '0;
            r_armed        <= 1'b0;
            r_triggered    <= 1'b0;
            r_capture_done <= 1'b0;
        end else if (run) begin
            // run outranks clr_done and any trigger arriving in the same cycle.
            r_state        <= ST_PRETRIG;
            r_waddr        <= '0;
            r_trig_addr    <= '0;
            r_cnt          <= '0;
            r_armed        <= 1'b0;
            r_triggered    <= 1'b0;
            r_capture_done <= 1'b0;
        end else begin
            if (w_we) begin
                r_waddr <= r_waddr + 1'b1;
            end

            case (r_state)
                ST_PRETRIG: begin
                    if (cap_en) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == w_pre_target) begin
                            r_state <= ST_ARMED;
                            r_armed <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (cap_en && w_trig_now) begin
                        r_trig_addr <= r_waddr;
                        r_cnt       <= {1'b0, trig_pos};
                        r_triggered <= 1'b1;
                        r_armed     <= 1'b0;
                        if (trig_pos == '0) begin
                            r_state        <= ST_DONE;
                            r_capture_done <= 1'b1;
                        end else begin
                            r_state <= ST_POSTTRIG;
                        end
                    end
                end
                ST_POSTTRIG: begin
                    if (cap_en) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state        <= ST_DONE;
                            r_capture_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (clr_done) begin
                        r_state        <= ST_IDLE;
                        r_capture_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign we           = w_we;
    assign waddr        = r_waddr;
    assign trig_addr    = r_trig_addr;
    assign armed        = r_armed;
    assign triggered    = r_triggered;
    assign capture_done = r_capture_done;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Directed bench for trig_capture_ctrl at ADDR_W=4 (DEPTH 16).
// Inputs change 1 ns after a rising edge; outputs are checked in that same window.
module tb_trig_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       clr_done = 1'b0;
    logic       cap_en = 1'b0;
    logic       SPItrig = 1'b0;
    logic       UARTtrig = 1'b0;
    logic       ext_trig = 1'b0;
    logic [2:0] trig_src = 3'b000;
    logic [3:0] trig_pos = 4'd0;
    logic       we;
    logic [3:0] waddr;
    logic [3:0] trig_addr;
    logic       armed;
    logic       triggered;
    logic       capture_done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;
    int w_snap;

    trig_capture_ctrl #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .clr_done     (clr_done),
        .cap_en       (cap_en),
        .SPItrig      (SPItrig),
        .UARTtrig     (UARTtrig),
        .ext_trig     (ext_trig),
        .trig_src     (trig_src),
        .trig_pos     (trig_pos),
        .we           (we),
        .waddr        (waddr),
        .trig_addr    (trig_addr),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done)
    );

    always #5 clk = ~clk;

    // Count RAM writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (we === 1'b1) n_writes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset: IDLE with cap_en high must not write.
        cap_en = 1'b1;
        tick();
        tick();
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_armed", armed, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", capture_done, 0);
        rst = 1'b0;

        // 1. Pre-trigger fill with trig_pos=4: 12 pre samples, trigger at 12, post 13..0.
        trig_pos = 4'd4;
        trig_src = 3'b001;
        w_snap = n_writes;
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (11) tick();
        check("t1_armed_after11", armed, 0);
        tick();
        check("t1_armed_after12", armed, 1);
        check("t1_waddr_armed", waddr, 12);
        check("t1_we_armed", we, 1);
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        check("t1_triggered", triggered, 1);
        check("t1_armed_drop", armed, 0);
        check("t1_trig_addr", trig_addr, 12);
        check("t1_waddr_post1", waddr, 13);
        tick();
        tick();
        tick();
        check("t1_waddr_last", waddr, 0);
        check("t1_we_last", we, 1);
        check("t1_done_early", capture_done, 0);
        tick();
        check("t1_done", capture_done, 1);
        check("t1_we_done", we, 0);
        check("t1_writes", n_writes - w_snap, 17);

        // 2. Early triggers ignored, masked source ignored, UART triggers.
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        check("t2_clr_done", capture_done, 0);
        check("t2_idle_we", we, 0);
        trig_src = 3'b011;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        tick();
        UARTtrig = 1'b1;
        tick();
        UARTtrig = 1'b0;
        repeat (6) tick();
        check("t2_armed_pre", armed, 0);
        check("t2_trig_pre", triggered, 0);
        tick();
        check("t2_armed", armed, 1);
        check("t2_waddr_armed", waddr, 12);
        trig_src = 3'b010;
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        check("t2_masked_spi", triggered, 0);
        check("t2_still_armed", armed, 1);
        trig_src = 3'b011;
        UARTtrig = 1'b1;
        tick();
        UARTtrig = 1'b0;
        check("t2_uart_trig", triggered, 1);
        check("t2_trig_addr", trig_addr, 13);
        repeat (3) tick();
        check("t2_done_early", capture_done, 0);
        tick();
        check("t2_done", capture_done, 1);

        // 3. Sparse strobe: trig_pos=2 -> 14 pre strobes; two pulses latched as one trigger.
        trig_pos = 4'd2;
        trig_src = 3'b001;
        cap_en = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (13) strobe();
        check("t3_armed_pre", armed, 0);
        strobe();
        check("t3_armed", armed, 1);
        check("t3_waddr_armed", waddr, 14);
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        check("t3_latched_not_taken", triggered, 0);
        tick();
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        check("t3_second_pulse", triggered, 0);
        cap_en = 1'b1;
        #1;
        check("t3_trig_we", we, 1);
        check("t3_trig_waddr", waddr, 14);
        tick();
        cap_en = 1'b0;
        check("t3_triggered", triggered, 1);
        check("t3_trig_addr", trig_addr, 14);
        check("t3_waddr_post", waddr, 15);
        strobe();
        check("t3_done_early", capture_done, 0);
        strobe();
        check("t3_done", capture_done, 1);
        check("t3_trig_addr_kept", trig_addr, 14);
        check("t3_waddr_final", waddr, 1);

        // 4a. trig_pos=0: 16 pre samples, DONE right after the trigger sample.
        cap_en = 1'b1;
        trig_pos = 4'd0;
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (15) tick();
        check("t4a_armed_pre", armed, 0);
        tick();
        check("t4a_armed", armed, 1);
        check("t4a_waddr_wrap", waddr, 0);
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        check("t4a_done", capture_done, 1);
        check("t4a_triggered", triggered, 1);
        check("t4a_trig_addr", trig_addr, 0);
        check("t4a_we", we, 0);
        check("t4a_waddr", waddr, 1);

        // 4b. trig_pos=15: one pre sample, fifteen post samples ending at address 0.
        trig_pos = 4'd15;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("t4b_armed", armed, 1);
        check("t4b_waddr_armed", waddr, 1);
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        check("t4b_trig_addr", trig_addr, 1);
        check("t4b_waddr_post", waddr, 2);
        repeat (14) tick();
        check("t4b_done_early", capture_done, 0);
        check("t4b_waddr_last", waddr, 0);
        check("t4b_we_last", we, 1);
        tick();
        check("t4b_done", capture_done, 1);
        check("t4b_waddr_final", waddr, 1);

        // 5. 40 samples before the trigger: trig_addr = 40 mod 16 = 8, last write 12.
        trig_pos = 4'd4;
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (12) tick();
        check("t5_armed", armed, 1);
        repeat (28) tick();
        check("t5_still_armed", armed, 1);
        check("t5_waddr_wrap", waddr, 8);
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        check("t5_trig_addr", trig_addr, 8);
        repeat (3) tick();
        check("t5_waddr_last", waddr, 12);
        check("t5_we_last", we, 1);
        tick();
        check("t5_done", capture_done, 1);
        check("t5_waddr_final", waddr, 13);

        // 6a. run during POSTTRIG restarts the capture.
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (12) tick();
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        tick();
        check("t6a_in_post", triggered, 1);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("t6a_triggered", triggered, 0);
        check("t6a_waddr", waddr, 0);
        check("t6a_trig_addr", trig_addr, 0);
        check("t6a_armed", armed, 0);

        // 6b. run beats a trigger in the same cycle.
        repeat (12) tick();
        check("t6b_armed", armed, 1);
        SPItrig = 1'b1;
        run = 1'b1;
        tick();
        SPItrig = 1'b0;
        run = 1'b0;
        check("t6b_triggered", triggered, 0);
        check("t6b_armed", armed, 0);
        check("t6b_waddr", waddr, 0);

        // 6c. run and clr_done together from DONE -> PRETRIG.
        trig_pos = 4'd15;
        tick();
        check("t6c_armed", armed, 1);
        SPItrig = 1'b1;
        tick();
        SPItrig = 1'b0;
        repeat (15) tick();
        check("t6c_done", capture_done, 1);
        run = 1'b1;
        clr_done = 1'b1;
        tick();
        run = 1'b0;
        clr_done = 1'b0;
        check("t6c_done_clr", capture_done, 0);
        check("t6c_pretrig_we", we, 1);
        check("t6c_waddr", waddr, 0);
        tick();
        check("t6c_rearmed", armed, 1);

        // 6d. Reset in ARMED clears every output next cycle.
        rst = 1'b1;
        tick();
        check("t6d_armed", armed, 0);
        check("t6d_waddr", waddr, 0);
        check("t6d_trig_addr", trig_addr, 0);
        check("t6d_we", we, 0);
        check("t6d_triggered", triggered, 0);
        check("t6d_done", capture_done, 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_capture_ctrl.md
# trig_capture_ctrl

Capture controller directly downstream of the SPI protocol trigger unit in the logic analyzer. Consumes the single-cycle `SPItrig` pulse, plus optional UART and external trigger pulses, gated by a source-enable mask. Drives the sample-RAM write strobe and a circular write address. Holds a programmable number of post-trigger samples and reports where the trigger sample landed so readback can unroll the buffer.

## Interface
Parameters:
- `ADDR_W`, default 9: sample-RAM address width; `DEPTH = 2**ADDR_W`.

Ports:
- `clk`  in  1: single system clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `run`  in  1: one-cycle pulse; (re)starts a capture.
- `clr_done`  in  1: one-cycle pulse; DONE→IDLE.
- `cap_en`  in  1: sample strobe (one per decimated sample).
- `SPItrig`  in  1: pulse from SPI trigger unit.
- `UARTtrig`  in  1: pulse from UART trigger unit.
- `ext_trig`  in  1: synchronized external trigger pulse.
- `trig_src`  in  3: enable mask `{ext, UART, SPI}`.
- `trig_pos`  in  ADDR_W: number of samples kept after the trigger sample.
- `we`  out  1: RAM write enable.
- `waddr`  out  ADDR_W: RAM write address.
- `trig_addr`  out  ADDR_W: address of the trigger sample.
- `armed`  out  1: pre-trigger fill complete, waiting for trigger.
- `triggered`  out  1: trigger accepted, post-trigger fill in progress or done.
- `capture_done`  out  1: buffer frozen, ready for readback.

## Operation
- States: IDLE, PRETRIG, ARMED, POSTTRIG, DONE.
- Transitions:
  - `run` in any state → PRETRIG. `waddr`, sample counter, pending latch, `trig_addr`, `triggered` and `capture_done` are cleared.
  - `run` takes priority over `clr_done` and over a trigger in the same cycle.
  - PRETRIG: on each `cap_en`, count samples. When the count reaches `DEPTH - tp` → ARMED. `tp = min(trig_pos, DEPTH-1)`.
  - Triggers arriving in PRETRIG are discarded, never latched.
  - ARMED: `hit = |(trig_src & {ext_trig, UARTtrig, SPItrig})` sets a pending latch. Trigger pulses need not coincide with `cap_en`.
  - ARMED, first `cap_en` with pending or `hit` set:
    - `trig_addr <= waddr`;
    - post counter `<= tp`;
    - `triggered <= 1`;
    - → POSTTRIG, or → DONE if `tp == 0`.
  - POSTTRIG: each `cap_en` decrements the post counter; at 1→0 → DONE.
  - DONE: `capture_done = 1`; stays until `clr_done` (→ IDLE) or `run`.
- Writes:
  - `we = cap_en` in PRETRIG, ARMED or POSTTRIG; otherwise 0. `we` is combinational from `cap_en` and the state register.
  - `waddr` increments after every write, wrapping `DEPTH-1`→0.
- ARMED may last many wraps; the buffer always holds the latest `DEPTH` samples.
- Trigger pulses in POSTTRIG/DONE/IDLE are ignored.

## Timing
- Reset values: state IDLE; `we=0`, `waddr=0`, `trig_addr=0`, `armed=0`, `triggered=0`, `capture_done=0`; pending latch clear.
- `armed`, `triggered` and `capture_done` are registered. They assert the cycle after the transition-causing edge.
- `we` follows `cap_en` in the same cycle (combinational). `waddr` is valid in the same cycle as `we`.
- The trigger sample is the `cap_en` sample on which the trigger is accepted. Exactly `tp` further samples are written after it; the last write is at `trig_addr + tp` (mod `DEPTH`).
- `SPItrig` with `cap_en` in the same cycle (ARMED): that sample is the trigger sample.
- Two enabled pulses before one `cap_en`: one trigger.
- `rst` mid-capture aborts immediately to reset values; RAM contents are undefined.

## Structure
- `trig_capture_pkg`: state enum `cap_state_t`, `TRIG_SPI/UART/EXT` bit-index constants.
- Sub-module `trig_sel`: source masking plus pending latch with clear-on-consume and clear-on-`run`. Output is `trig_now = pending | hit`.
- Top: FSM, write-address counter, pre/post sample counters, `trig_addr` register.

## Test plan
All with `ADDR_W=4` (DEPTH 16), `cap_en` every cycle unless stated.
1. Pre-trigger fill: `trig_pos=4`, `trig_src=001`, run → `armed` after exactly 12 writes, `waddr=12`. `SPItrig` → `trig_addr=12`, writes at 13,14,15,0, then `capture_done`, `we=0`.
2. Early trigger: `SPItrig` pulsed during PRETRIG → ignored. Later `UARTtrig` with `trig_src=011` → triggers. `SPItrig` with `trig_src=010` → ignored.
3. Sparse strobe: `cap_en` every 4th cycle, `SPItrig` between strobes → latched. Next strobe sample is the trigger sample; one trigger only.
4. Edge `trig_pos`: value 0 → DONE right after the trigger sample. Value 15 → 1 pre-sample, 15 post. Value ≥ 16 via wide stim is not applicable; 15 is the clamp boundary.
5. Wrap: ARMED for 40 samples before trigger → `waddr` wraps correctly, `trig_addr = 40 mod 16 = 8`, final write at `8+tp`.
6. Control: `run` during POSTTRIG restarts (`triggered=0`, `waddr=0`). `run` and `clr_done` in the same cycle → PRETRIG. `rst` in ARMED → all outputs 0 next cycle.
